// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control logic: hazard FSM states, register
// index type, the bundle of pipeline-register controls and helpers that
// evaluate the load-use and run-time control rules.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hz_state_t;

    // Write enable / flush for PC and the four pipeline registers.
    typedef struct packed {
        logic pc_w;
        logic ifid_w;
        logic ifid_rst;
        logic id_w;
        logic id_rst;
        logic exmem_w;
        logic exmem_rst;
        logic memwb_w;
        logic memwb_rst;
    } hz_ctrl_t;

    // Every register in reset: nothing written, every flush asserted.
    localparam hz_ctrl_t HZ_CTRL_RESET = '{
        pc_w: 1'b0, ifid_w: 1'b0, ifid_rst: 1'b1, id_w: 1'b0, id_rst: 1'b1,
        exmem_w: 1'b0, exmem_rst: 1'b1, memwb_w: 1'b0, memwb_rst: 1'b1
    };

    // A load in EX whose destination feeds the instruction in ID.
    // r0 is hard-wired to zero, so a load into it never creates a dependency.
    function automatic logic is_load_use(
        input logic     ex_load,
        input regbits_t ex_rt,
        input regbits_t id_rs,
        input regbits_t id_rt,
        input logic     id_uses_rt
    );
        return ex_load && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    // Branch flush, load-use bubble, fetch miss or free-running pipeline,
    // in that order of priority. Shared by RUN and the DWAIT exit cycle.
    function automatic hz_ctrl_t run_rules(
        input logic branch_taken,
        input logic load_use,
        input logic ihit
    );
        hz_ctrl_t c;
        c = '{
            pc_w: 1'b1, ifid_w: 1'b1, ifid_rst: 1'b0, id_w: 1'b1, id_rst: 1'b0,
            exmem_w: 1'b1, exmem_rst: 1'b0, memwb_w: 1'b1, memwb_rst: 1'b0
        };
        if (branch_taken) begin
            c.ifid_rst = 1'b1;
            c.id_rst   = 1'b1;
        end else if (load_use) begin
            c.pc_w   = 1'b0;
            c.ifid_w = 1'b0;
            c.id_rst = 1'b1;
        end else if (!ihit) begin
            c.pc_w     = 1'b0;
            c.ifid_rst = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import cpu_types_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Advance on enable unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline control for the five-stage core: PC / pipeline-register write
// enables and flushes, data-wait and halt sequencing, stall/flush counters.
//
// state | meaning
// RUN   | normal issue; hazards resolved combinationally each cycle
// DWAIT | MEM access outstanding; pipeline frozen until dhit
// HALT  | halt retired; everything frozen until reset
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_cuDRE,
    input  regbits_t         ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_cuDRE,
    input  logic             mem_cuDWE,
    input  logic             mem_halt,
    output logic             pcW,
    output logic             ifidW,
    output logic             ifidRST,
    output logic             idW,
    output logic             idRST,
    output logic             exmemW,
    output logic             exmemRST,
    output logic             memwbW,
    output logic             memwbRST,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state_q;
    hz_state_t state_d;
    hz_ctrl_t  ctl;
    logic      load_use;
    logic      stall_en;
    logic      flush_en;

    assign load_use = is_load_use(ex_cuDRE, ex_rt, id_rs, id_rt, id_uses_rt);

    // Next state, pipeline controls and counter events; reset overrides all.
    always_comb begin
        state_d  = state_q;
        ctl      = '0;
        flush_en = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_halt) begin
                    ctl.memwb_w = 1'b1;
                    state_d     = HALT;
                end else if ((mem_cuDRE || mem_cuDWE) && !dhit) begin
                    state_d = DWAIT;
                end else begin
                    ctl      = run_rules(ex_branch_taken, load_use, ihit);
                    flush_en = ex_branch_taken;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    ctl      = run_rules(ex_branch_taken, load_use, ihit);
                    flush_en = ex_branch_taken;
                    state_d  = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // A halted core is not stalling; those cycles are not counted.
        stall_en = (state_q != HALT) && !ctl.pc_w;
        if (!nRST) begin
            ctl      = HZ_CTRL_RESET;
            stall_en = 1'b0;
            flush_en = 1'b0;
            state_d  = RUN;
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (stall_en),
        .cnt  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (flush_en),
        .cnt  (flush_cnt)
    );

    assign pcW      = ctl.pc_w;
    assign ifidW    = ctl.ifid_w;
    assign ifidRST  = ctl.ifid_rst;
    assign idW      = ctl.id_w;
    assign idRST    = ctl.id_rst;
    assign exmemW   = ctl.exmem_w;
    assign exmemRST = ctl.exmem_rst;
    assign memwbW   = ctl.memwb_w;
    assign memwbRST = ctl.memwb_rst;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default-width instance plus a 4-bit
// counter instance sharing the same stimulus for the saturation case.
module tb_hazard_unit;

    logic       CLK;
    logic       nRST;
    logic       ihit, dhit;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_cuDRE, ex_branch_taken;
    logic       mem_cuDRE, mem_cuDWE, mem_halt;

    logic        pcW, ifidW, ifidRST, idW, idRST, exmemW, exmemRST, memwbW, memwbRST, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pcW4, ifidW4, ifidRST4, idW4, idRST4, exmemW4, exmemRST4, memwbW4, memwbRST4, halted4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    logic [8:0] ctl;
    assign ctl = {pcW, ifidW, ifidRST, idW, idRST, exmemW, exmemRST, memwbW, memwbRST};

    // {pcW, ifidW, ifidRST, idW, idRST, exmemW, exmemRST, memwbW, memwbRST}
    localparam logic [8:0] C_NORMAL = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_ALL0   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_RESET  = 9'b0_0_1_0_1_0_1_0_1;
    localparam logic [8:0] C_LDUSE  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] C_BRANCH = 9'b1_1_1_1_1_1_0_1_0;
    localparam logic [8:0] C_IMISS  = 9'b0_1_1_1_0_1_0_1_0;
    localparam logic [8:0] C_HALTIN = 9'b0_0_0_0_0_0_0_1_0;

    int n_cmp = 0;
    int n_err = 0;

    hazard_unit dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_cuDRE(ex_cuDRE), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_cuDRE(mem_cuDRE), .mem_cuDWE(mem_cuDWE), .mem_halt(mem_halt),
        .pcW(pcW), .ifidW(ifidW), .ifidRST(ifidRST), .idW(idW), .idRST(idRST),
        .exmemW(exmemW), .exmemRST(exmemRST), .memwbW(memwbW), .memwbRST(memwbRST),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_cuDRE(ex_cuDRE), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_cuDRE(mem_cuDRE), .mem_cuDWE(mem_cuDWE), .mem_halt(mem_halt),
        .pcW(pcW4), .ifidW(ifidW4), .ifidRST(ifidRST4), .idW(idW4), .idRST(idRST4),
        .exmemW(exmemW4), .exmemRST(exmemRST4), .memwbW(memwbW4), .memwbRST(memwbRST4),
        .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are then driven there.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b1;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_cuDRE = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        mem_cuDRE = 1'b0; mem_cuDWE = 1'b0; mem_halt = 1'b0;
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        #1;
        chk("reset_ctl", 32'(ctl), 32'(C_RESET));
        tick();
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        chk("reset_flush", 32'(flush_cnt), 32'd0);

        nRST = 1'b1;
        #1 chk("idle_ctl", 32'(ctl), 32'(C_NORMAL));
        tick();

        // load r5 in EX, ID reads r5 through rs
        ex_cuDRE = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1 chk("lduse_rs_ctl", 32'(ctl), 32'(C_LDUSE));
        tick();
        idle();
        #1 chk("lduse_release_ctl", 32'(ctl), 32'(C_NORMAL));
        chk("lduse_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // load into r0 never stalls
        ex_cuDRE = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 chk("lduse_r0_ctl", 32'(ctl), 32'(C_NORMAL));
        tick();
        // rt match only matters when ID actually reads rt
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
        #1 chk("lduse_rt_unused_ctl", 32'(ctl), 32'(C_NORMAL));
        tick();
        id_uses_rt = 1'b1;
        #1 chk("lduse_rt_ctl", 32'(ctl), 32'(C_LDUSE));
        tick();
        idle();
        #1 chk("lduse_rt_stall_cnt", 32'(stall_cnt), 32'd2);

        // store stuck for 3 cycles, then completes
        mem_cuDWE = 1'b1; dhit = 1'b0;
        #1 chk("dwait1_ctl", 32'(ctl), 32'(C_ALL0));
        tick();
        mem_halt = 1'b1;
        #1 chk("dwait2_ignores_halt_ctl", 32'(ctl), 32'(C_ALL0));
        tick();
        mem_halt = 1'b0;
        #1 chk("dwait3_ctl", 32'(ctl), 32'(C_ALL0));
        tick();
        dhit = 1'b1;
        #1 chk("dwait_release_ctl", 32'(ctl), 32'(C_NORMAL));
        chk("dwait_stall_cnt", 32'(stall_cnt), 32'd5);
        tick();
        idle();
        #1 chk("dwait_after_halted", 32'(halted), 32'd0);
        chk("dwait_after_stall_cnt", 32'(stall_cnt), 32'd5);

        // branch beats load-use
        ex_branch_taken = 1'b1; ex_cuDRE = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1 chk("branch_lduse_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        idle();
        #1 chk("branch_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("branch_no_stall", 32'(stall_cnt), 32'd5);

        // branch waits behind a pending data read
        mem_cuDRE = 1'b1; dhit = 1'b0; ex_branch_taken = 1'b1;
        #1 chk("br_dwait1_ctl", 32'(ctl), 32'(C_ALL0));
        tick();
        #1 chk("br_dwait2_ctl", 32'(ctl), 32'(C_ALL0));
        chk("br_dwait_flush_cnt", 32'(flush_cnt), 32'd1);
        tick();
        dhit = 1'b1;
        #1 chk("br_dwait_exit_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        idle();
        #1 chk("br_dwait_flush_cnt2", 32'(flush_cnt), 32'd2);
        chk("br_dwait_stall_cnt", 32'(stall_cnt), 32'd7);

        // fetch miss
        ihit = 1'b0;
        #1 chk("imiss_ctl", 32'(ctl), 32'(C_IMISS));
        tick();
        ihit = 1'b1;
        #1 chk("imiss_stall_cnt", 32'(stall_cnt), 32'd8);

        // halt
        mem_halt = 1'b1;
        #1 chk("halt_in_ctl", 32'(ctl), 32'(C_HALTIN));
        chk("halt_in_halted", 32'(halted), 32'd0);
        tick();
        mem_halt = 1'b0;
        #1 chk("halted_flag", 32'(halted), 32'd1);
        chk("halted_ctl", 32'(ctl), 32'(C_ALL0));
        chk("halt_stall_cnt", 32'(stall_cnt), 32'd9);
        ihit = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 chk("halt_hold_ctl", 32'(ctl), 32'(C_ALL0));
            chk("halt_hold_halted", 32'(halted), 32'd1);
            chk("halt_frozen_stall", 32'(stall_cnt), 32'd9);
            chk("halt_frozen_flush", 32'(flush_cnt), 32'd2);
        end
        idle();
        nRST = 1'b0;
        #1 chk("halt_reset_ctl", 32'(ctl), 32'(C_RESET));
        tick();
        nRST = 1'b1;
        #1 chk("post_reset_halted", 32'(halted), 32'd0);
        chk("post_reset_stall", 32'(stall_cnt), 32'd0);
        chk("post_reset_flush", 32'(flush_cnt), 32'd0);
        chk("post_reset_ctl", 32'(ctl), 32'(C_NORMAL));

        // 20 consecutive fetch misses: 4-bit counter sticks at 15
        ihit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            #1 chk("sat4_stall", 32'(stall_cnt4), (i > 15) ? 32'd15 : 32'(i));
        end
        chk("sat16_stall", 32'(stall_cnt), 32'd20);
        ihit = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
